// File: rtl/imem_loader.sv
// imem_loader: packs a big-endian byte stream (length word, then instruction words)
// into 32-bit writes to instruction memory, holding the core until a legal image is in.
`default_nettype none

module imem_loader #(
    parameter int          DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic        in_valid_i,
    input  logic [7:0]  in_data_i,
    output logic        in_ready_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic        core_run_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o
);

    localparam int          WIW     = $clog2(DEPTH) + 1;
    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LEN   = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_ERROR = 3'd5;

    logic [2:0]     state_q,    state_d;
    logic [1:0]     byte_cnt_q, byte_cnt_d;
    logic [23:0]    shift_q,    shift_d;
    logic [WIW-1:0] len_q,      len_d;
    logic [WIW-1:0] word_idx_q, word_idx_d;
    logic [31:0]    addr_q,     addr_d;
    logic [31:0]    wdata_q,    wdata_d;

    logic           w_accept;
    logic           w_last_byte;
    logic [31:0]    w_word;
    logic [WIW-1:0] w_idx_inc;

    // Ready depends on state alone so the host never sees a combinational loop.
    assign w_accept    = in_valid_i && ((state_q == S_LEN) || (state_q == S_DATA));
    assign w_last_byte = (byte_cnt_q == 2'd3);
    assign w_word      = {shift_q, in_data_i};
    assign w_idx_inc   = word_idx_q + WIW'(1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            byte_cnt_q <= 2'd0;
            shift_q    <= 24'd0;
            len_q      <= '0;
            word_idx_q <= '0;
            addr_q     <= BASE_ADDR;
            wdata_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            len_q      <= len_d;
            word_idx_q <= word_idx_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        len_d      = len_q;
        word_idx_d = word_idx_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;

        if (w_accept) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            shift_d    = {shift_q[15:0], in_data_i};
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_d    = S_LEN;
                    byte_cnt_d = 2'd0;
                end
            end
            S_LEN: begin
                if (w_accept && w_last_byte) begin
                    if (w_word == 32'd0) begin
                        state_d = S_DONE;
                    end else if (w_word > DEPTH_W) begin
                        state_d = S_ERROR;
                    end else begin
                        state_d    = S_DATA;
                        len_d      = w_word[WIW-1:0];
                        word_idx_d = '0;
                    end
                end
            end
            S_DATA: begin
                if (w_accept && w_last_byte) begin
                    state_d = S_WRITE;
                    addr_d  = BASE_ADDR + 32'({word_idx_q, 2'b00});
                    wdata_d = w_word;
                end
            end
            S_WRITE: begin
                word_idx_d = w_idx_inc;
                state_d    = (w_idx_inc == len_q) ? S_DONE : S_DATA;
            end
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready_o  = (state_q == S_LEN) || (state_q == S_DATA);
        mem_we_o    = (state_q == S_WRITE);
        busy_o      = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_WRITE);
        done_o      = (state_q == S_DONE);
        core_run_o  = (state_q == S_DONE);
        error_o     = (state_q == S_ERROR);
        mem_addr_o  = addr_q;
        mem_wdata_o = wdata_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: two instances (base 0x0 and 0x100) share one stimulus stream;
// expected writes are derived from the byte image by the image-format rules.
`default_nettype none

module tb_imem_loader;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;

    logic        rdy0, we0, run0, busy0, done0, err0;
    logic [31:0] addr0, wd0;
    logic        rdy1, we1, run1, busy1, done1, err1;
    logic [31:0] addr1, wd1;

    int checks   = 0;
    int failures = 0;
    int rdy_viol = 0;

    logic [7:0]  img[$];
    logic [31:0] cap_a0[$], cap_d0[$], cap_a1[$], cap_d1[$];

    always #5 clk = ~clk;

    imem_loader #(.DEPTH(DEPTH), .BASE_ADDR(32'h0)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .in_valid_i(in_valid),
        .in_data_i(in_data), .in_ready_o(rdy0), .mem_we_o(we0), .mem_addr_o(addr0),
        .mem_wdata_o(wd0), .core_run_o(run0), .busy_o(busy0), .done_o(done0),
        .error_o(err0)
    );

    imem_loader #(.DEPTH(DEPTH), .BASE_ADDR(32'h100)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .in_valid_i(in_valid),
        .in_data_i(in_data), .in_ready_o(rdy1), .mem_we_o(we1), .mem_addr_o(addr1),
        .mem_wdata_o(wd1), .core_run_o(run1), .busy_o(busy1), .done_o(done1),
        .error_o(err1)
    );

    always @(negedge clk) begin
        if (we0) begin
            cap_a0.push_back(addr0);
            cap_d0.push_back(wd0);
            if (rdy0) rdy_viol++;
        end
        if (we1) begin
            cap_a1.push_back(addr1);
            cap_d1.push_back(wd1);
            if (rdy1) rdy_viol++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offer one byte; mid_word marks a point where the loader must be waiting for bytes.
    task automatic send_byte(input logic [7:0] b, input bit gaps, input bit mid_word);
        int n;
        if (gaps && ($urandom_range(0, 1) == 1)) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            if (mid_word) check("ready_in_gap", 32'(rdy0), 32'd1);
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (!rdy0 && n < 64) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", 32'(rdy0), 32'd1);
        @(negedge clk);
        if (gaps) in_valid = 1'b0;
    endtask

    task automatic clear_caps();
        cap_a0.delete(); cap_d0.delete(); cap_a1.delete(); cap_d1.delete();
        rdy_viol = 0;
    endtask

    // Loads img and compares the write streams and final status against the image rules.
    task automatic run_image(input bit gaps);
        logic [31:0] n;
        logic [31:0] w;
        int          nw;
        bit          exp_err;
        clear_caps();
        pulse_start();
        check("run_after_start", 32'(run0), 32'd0);
        check("busy_after_start", 32'(busy0), 32'd1);
        foreach (img[i]) send_byte(img[i], gaps, (i % 4) != 0);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);

        n       = {img[0], img[1], img[2], img[3]};
        exp_err = (n > 32'(DEPTH));
        nw      = exp_err ? 0 : int'(n);
        check("nwrites0", 32'(cap_a0.size()), 32'(nw));
        check("nwrites1", 32'(cap_a1.size()), 32'(nw));
        for (int k = 0; k < nw; k++) begin
            w = {img[4+4*k], img[5+4*k], img[6+4*k], img[7+4*k]};
            if (k < cap_a0.size()) begin
                check("addr0", cap_a0[k], 32'(4 * k));
                check("data0", cap_d0[k], w);
            end
            if (k < cap_a1.size()) begin
                check("addr1", cap_a1[k], 32'h100 + 32'(4 * k));
                check("data1", cap_d1[k], w);
            end
        end
        check("done", 32'(done0), 32'(!exp_err));
        check("core_run", 32'(run0), 32'(!exp_err));
        check("core_run1", 32'(run1), 32'(!exp_err));
        check("error", 32'(err0), 32'(exp_err));
        check("busy_end", 32'(busy0), 32'd0);
        check("ready_in_write", 32'(rdy_viol), 32'd0);
    endtask

    task automatic set_len(input logic [31:0] n);
        img.delete();
        img.push_back(n[31:24]); img.push_back(n[23:16]);
        img.push_back(n[15:8]);  img.push_back(n[7:0]);
    endtask

    task automatic push_word(input logic [31:0] w);
        img.push_back(w[31:24]); img.push_back(w[23:16]);
        img.push_back(w[15:8]);  img.push_back(w[7:0]);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(rdy0), 32'd0);
        check("rst_we", 32'(we0), 32'd0);
        check("rst_run", 32'(run0), 32'd0);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_done", 32'(done0), 32'd0);
        check("rst_error", 32'(err0), 32'd0);
        check("rst_addr0", addr0, 32'h0);
        check("rst_addr1", addr1, 32'h100);
        check("rst_wdata", wd0, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed two-word program, continuous then gapped stream.
        set_len(32'd2); push_word(32'h2008_0005); push_word(32'h0109_5020);
        run_image(1'b0);
        run_image(1'b1);

        set_len(32'd0);
        run_image(1'b0);

        repeat (4) begin
            set_len(32'($urandom_range(1, 5)));
            for (int k = 0; k < int'(img[3]); k++) push_word($urandom);
            run_image(1'($urandom_range(0, 1)));
        end

        check("run_before_reload", 32'(run0), 32'd1);
        set_len(32'd1); push_word(32'hFFFF_FFFF);
        run_image(1'b0);

        // Reset asynchronously between edges, two bytes into the first data word.
        clear_caps();
        set_len(32'd2); push_word(32'h1234_5678); push_word(32'h9ABC_DEF0);
        pulse_start();
        for (int i = 0; i < 6; i++) send_byte(img[i], 1'b0, (i % 4) != 0);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy0), 32'd0);
        check("mid_rst_ready", 32'(rdy0), 32'd0);
        check("mid_rst_run", 32'(run0), 32'd0);
        check("mid_rst_addr1", addr1, 32'h100);
        check("mid_rst_writes", 32'(cap_a0.size()), 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_image(1'b1);

        // Oversized length locks into ERROR until reset.
        set_len(32'(DEPTH + 1));
        run_image(1'b0);
        pulse_start();
        repeat (3) @(negedge clk);
        check("err_sticky", 32'(err0), 32'd1);
        check("err_ready", 32'(rdy0), 32'd0);
        check("err_busy", 32'(busy0), 32'd0);
        check("err_run", 32'(run0), 32'd0);
        check("err_writes", 32'(cap_a0.size()), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("err_cleared", 32'(err0), 32'd0);
        check("err_rst_done", 32'(done0), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_after_rst", 32'(busy0 | done0 | err0), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
